// File: rtl/spfp_mul_sched.sv
// Round-robin scheduler sharing one 24x24 mantissa multiplier tree
// between two single-precision FP requesters.
module spfp_mul_sched #(
  parameter int TREE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        busy,
  output logic [23:0] tree_op1,
  output logic [23:0] tree_op2,
  input  logic [47:0] tree_product
);

  localparam int CW = (TREE_CYCLES > 1) ? $clog2(TREE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          last;
  logic [1:0]    grant;
  logic          accept;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          id_q;
  logic [CW-1:0] cnt;
  logic          cnt_done;
  logic [47:0]   prod_q;
  logic [31:0]   a_sel;
  logic [31:0]   b_sel;
  logic [31:0]   res;

  logic                sgn;
  logic [7:0]          ea;
  logic [7:0]          eb;
  logic                nan_a;
  logic                nan_b;
  logic                inf_a;
  logic                inf_b;
  logic                zero_a;
  logic                zero_b;
  logic signed [9:0]   e_sum;
  logic signed [9:0]   e_adj;
  logic [22:0]         frac;

  assign cnt_done = (cnt == CW'(TREE_CYCLES - 1));
  assign accept   = |(req_valid & req_ready);
  assign a_sel    = grant[1] ? req_a1 : req_a0;
  assign b_sel    = grant[1] ? req_b1 : req_b0;

  // Round-robin grant: a lone requester wins, a tie goes to the one
  // not served last.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      default: grant = last ? 2'b01 : 2'b10;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)    state_nxt = MUL;
      MUL:  if (cnt_done)  state_nxt = NORM;
      NORM:                state_nxt = DONE;
      DONE: if (rsp_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !rst) req_ready = grant;
    busy      = (state != IDLE);
    rsp_valid = (state == DONE);
  end

  // Operand capture, multicycle counter, product and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last       <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      cnt        <= '0;
      prod_q     <= '0;
      tree_op1   <= '0;
      tree_op2   <= '0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= a_sel;
            b_q      <= b_sel;
            id_q     <= grant[1];
            last     <= grant[1];
            cnt      <= '0;
            tree_op1 <= {1'b1, a_sel[22:0]};
            tree_op2 <= {1'b1, b_sel[22:0]};
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (cnt_done) prod_q <= tree_product;
        end
        NORM: begin
          rsp_result <= res;
          rsp_id     <= id_q;
        end
        default: ;
      endcase
    end
  end

  // Normalize, derive exponent and apply special-value overrides.
  always_comb begin
    sgn    = a_q[31] ^ b_q[31];
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    nan_a  = (ea == 8'hFF) && (a_q[22:0] != 23'h0);
    nan_b  = (eb == 8'hFF) && (b_q[22:0] != 23'h0);
    inf_a  = (ea == 8'hFF) && (a_q[22:0] == 23'h0);
    inf_b  = (eb == 8'hFF) && (b_q[22:0] == 23'h0);
    zero_a = (ea == 8'h00);
    zero_b = (eb == 8'h00);
    e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    e_adj  = prod_q[47] ? e_sum + 10'sd1 : e_sum;
    frac   = prod_q[47] ? prod_q[46:24] : prod_q[45:23];
    res    = {sgn, e_adj[7:0], frac};
    if (e_adj >= 10'sd255) res = {sgn, 8'hFF, 23'h0};
    else if (e_adj <= 10'sd0) res = {sgn, 31'h0};
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
      res = 32'h7FC00000;
    else if (inf_a || inf_b)
      res = {sgn, 8'hFF, 23'h0};
    else if (zero_a || zero_b)
      res = {sgn, 31'h0};
  end

endmodule

// File: doc/spfp_mul_sched.md
# spfp_mul_sched

Round-robin scheduler that shares one combinational 24x24 Wallace-tree mantissa multiplier between two single-precision floating-point requesters.
- It accepts IEEE-754 operand pairs over a valid/ready handshake and drives the tree's mantissa inputs for a fixed multicycle window.
- It then captures the 48-bit product, normalizes it, applies exponent and special-case rules, and returns a tagged 32-bit result.
- It sits between the SPFP requesters and the single shared tree instance.

## Interface
- TREE_CYCLES, default 2: cycles the tree inputs are held stable before the product is sampled (multicycle path). Must be ≥ 1.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  2  per-requester operand valid ([0] = requester 0)
- req_ready  out  2  per-requester accept; at most one bit high
- req_a0, req_b0  in  32 each  requester 0 operands (IEEE-754 single)
- req_a1, req_b1  in  32 each  requester 1 operands
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester index the result belongs to
- rsp_result  out  32  IEEE-754 single product
- busy  out  1  high in any state other than IDLE
- tree_op1, tree_op2  out  24 each  mantissas with hidden bit, to the tree
- tree_product  in  48  tree product (tree carry-out unused)

## Operation
**FSM states:** IDLE, MUL, NORM, DONE.
- **IDLE:** grant per the arbitration rules below.
  - `req_ready[g]` = (state == IDLE) and (g is the granted requester), combinationally.
  - Accept occurs when `req_valid[g]` and `req_ready[g]` are both high on an edge. That edge latches the operands and g, updates the pointer, and moves to MUL.
- **MUL:** registered mantissas drive `tree_op1`/`tree_op2`, held constant. A counter runs TREE_CYCLES cycles. On the final MUL edge, register `tree_product` and move to NORM.
- **NORM:** one cycle. Compute the result per the rules below, register it into `rsp_result`/`rsp_id`, move to DONE.
- **DONE:** `rsp_valid` = 1. Move to IDLE on the edge where `rsp_ready` = 1. `rsp_result`/`rsp_id` are held stable while waiting.

**Arbitration:** round-robin with a last-granted pointer.
- Only one requester valid: grant it.
- Both valid: grant the one not granted last.
- After reset, requester 0 wins the first tie.
- A request that is not accepted must be held by its requester; the scheduler never drops a request.

**Arithmetic:**
- sign = sa ^ sb.
- Mantissa = {1, frac}. Exponent 0 is treated as zero (denormals flushed).
- Exponent uses a 10-bit signed sum: e = ea + eb − 127.
- If `product[47]` = 1: frac = product[46:24], e = e + 1. Otherwise frac = product[45:23].
- Rounding is truncation (toward zero).
- e ≥ 255 → {sign, 8'hFF, 23'h0}. e ≤ 0 → {sign, 31'h0}.

**Special cases** (override the arithmetic, same latency):
- Either operand NaN, or inf×0 → 32'h7FC00000.
- inf × nonzero → {sign, 8'hFF, 23'h0}.
- Either operand zero or denormal → {sign, 31'h0}.

## Timing
- Reset values: state IDLE; `req_ready` 0 while rst is high; `rsp_valid` 0; `rsp_result` 32'h0; `rsp_id` 0; `busy` 0; `tree_op1`/`tree_op2` 24'h0; pointer set so requester 0 wins the first tie.
- Accept at edge t → `rsp_valid` rises after edge t + TREE_CYCLES + 1 (TREE_CYCLES MUL cycles, then one NORM cycle).
- With `rsp_ready` held high, throughput is one operation per TREE_CYCLES + 3 cycles.
  - No accept in DONE; the earliest next accept is the first IDLE cycle.
- `req_valid` arriving while busy: `req_ready` stays 0 until IDLE. The request is then arbitrated with the updated pointer.
- Reset asserted mid-operation: immediate abort to IDLE with all reset values. No response is issued for the aborted operation.
- `tree_op1`/`tree_op2` change only on the accept edge. They never change during MUL.

## Test plan
- **Basic multiply:** req0 a=0x3FC00000, b=0x40000000, TREE_CYCLES=2 → `rsp_valid` 3 edges after accept, `rsp_result`=0x40400000, `rsp_id`=0.
- **Normalization path:** a=b=0x3FC00000 (1.5×1.5) → 0x40100000 (product[47] set, exponent +1).
- **Round-robin:** both `req_valid` held high from reset, 4 operations → `rsp_id` sequence 0,1,0,1. With req1 alone valid → `rsp_id` 1 each time.
- **Special values:**
  - 0x7F000000 × 0x7F000000 → 0x7F800000 (overflow).
  - 0x00800000 × 0x00800000 → 0x00000000 (underflow).
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0xC0000000 × 0x7F800000 → 0xFF800000.
- **Backpressure:** `rsp_ready` low for 5 cycles in DONE → `rsp_valid`, `rsp_result`, `rsp_id` stable and `req_ready` 0 throughout. The next accept occurs the cycle after `rsp_ready` is seen high.
- **Reset mid-MUL:** assert rst during the first MUL cycle → all outputs at reset values immediately, no `rsp_valid` afterward. The next request completes normally with a correct result.
